// File: rtl/fb_sprite_writer_if.sv
// Sprite-writer bus bundle: the sprite ROM read port and the frame-buffer write port.
// The writer uses the master side; the ROM/frame-buffer side uses the slave side.
interface fb_sprite_writer_if #(
   parameter int PIX_W = 5
);
   logic [12:0]      rom_addr;
   logic [PIX_W-1:0] rom_data;
   logic             fb_we;
   logic [16:0]      fb_addr;
   logic [PIX_W-1:0] fb_wdata;

   modport master (
      output rom_addr, fb_we, fb_addr, fb_wdata,
      input  rom_data
   );

   modport slave (
      input  rom_addr, fb_we, fb_addr, fb_wdata,
      output rom_data
   );
endinterface

// File: rtl/fb_sprite_writer.sv
// Frame-buffer writer: on each vs falling edge, clears the back buffer to bg_color.
// It then blits one 32x32 sprite with transparency, clipping at the screen edges.
module fb_sprite_writer #(
   parameter int               FB_W   = 320,
   parameter int               FB_H   = 240,
   parameter int               SPR_W  = 32,
   parameter int               SPR_H  = 32,
   parameter int               PIX_W  = 5,
   parameter logic [PIX_W-1:0] TRANSP = '0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  vs,
   input  logic [9:0]            sprite_x,
   input  logic [9:0]            sprite_y,
   input  logic [2:0]            sprite_id,
   input  logic [PIX_W-1:0]      bg_color,
   fb_sprite_writer_if.master    bus,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);
   localparam int          COL_W     = $clog2(SPR_W);
   localparam int          ROW_W     = $clog2(SPR_H);
   localparam logic [16:0] CLR_LAST  = 17'(FB_W * FB_H - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);
   localparam logic [10:0] FB_W11    = 11'(FB_W);
   localparam logic [10:0] FB_H11    = 11'(FB_H);

   typedef enum logic [2:0] {IDLE, CLEAR, DRAW, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic             vs_s1_q, vs_s2_q, vs_s3_q;
   logic             frame_start_q, frame_start_d;
   logic [9:0]       sx_q, sx_d, sy_q, sy_d;
   logic [2:0]       id_q, id_d;
   logic [PIX_W-1:0] bg_q, bg_d;
   logic [16:0]      clr_q, clr_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             drain_q, drain_d;
   logic             overrun_q, overrun_d;
   logic             s1_vld_q, s1_vld_d;
   logic [10:0]      s1_x_q, s1_x_d, s1_y_q, s1_y_d;
   logic             s2_we_q, s2_we_d;
   logic [16:0]      s2_addr_q, s2_addr_d;
   logic [PIX_W-1:0] s2_data_q, s2_data_d;

   // vs is asynchronous and idles high, so the chain resets to 1 to avoid a false edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vs_s1_q <= 1'b1;
         vs_s2_q <= 1'b1;
         vs_s3_q <= 1'b1;
      end else begin
         vs_s1_q <= vs;
         vs_s2_q <= vs_s1_q;
         vs_s3_q <= vs_s2_q;
      end
   end

   assign frame_start_d = vs_s3_q & ~vs_s2_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         frame_start_q <= 1'b0;
         sx_q          <= '0;
         sy_q          <= '0;
         id_q          <= '0;
         bg_q          <= '0;
         clr_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         drain_q       <= 1'b0;
         overrun_q     <= 1'b0;
         s1_vld_q      <= 1'b0;
         s1_x_q        <= '0;
         s1_y_q        <= '0;
         s2_we_q       <= 1'b0;
         s2_addr_q     <= '0;
         s2_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         frame_start_q <= frame_start_d;
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         id_q          <= id_d;
         bg_q          <= bg_d;
         clr_q         <= clr_d;
         col_q         <= col_d;
         row_q         <= row_d;
         drain_q       <= drain_d;
         overrun_q     <= overrun_d;
         s1_vld_q      <= s1_vld_d;
         s1_x_q        <= s1_x_d;
         s1_y_q        <= s1_y_d;
         s2_we_q       <= s2_we_d;
         s2_addr_q     <= s2_addr_d;
         s2_data_q     <= s2_data_d;
      end
   end

   // A frame start outside IDLE is dropped, but remembered in the sticky overrun flag.
   always_comb begin
      state_d   = state_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      id_d      = id_q;
      bg_d      = bg_q;
      clr_d     = clr_q;
      col_d     = col_q;
      row_d     = row_q;
      drain_d   = drain_q;
      overrun_d = overrun_q | (frame_start_q && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (frame_start_q) begin
               sx_d    = sprite_x;
               sy_d    = sprite_y;
               id_d    = sprite_id;
               bg_d    = bg_color;
               clr_d   = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (clr_q == CLR_LAST) begin
               clr_d   = '0;
               col_d   = '0;
               row_d   = '0;
               state_d = DRAW;
            end else begin
               clr_d = clr_q + 17'd1;
            end
         end
         DRAW: begin
            col_d = col_q + 1'b1;
            if (col_q == COL_LAST) begin
               row_d = row_q + 1'b1;
            end
            if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
               drain_d = 1'b0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Stage 1 lines up screen coordinates with the ROM latency; stage 2 clips and linearises.
   always_comb begin
      s1_vld_d  = (state_q == DRAW);
      s1_x_d    = {1'b0, sx_q} + 11'(col_q);
      s1_y_d    = {1'b0, sy_q} + 11'(row_q);
      s2_we_d   = s1_vld_q && (bus.rom_data != TRANSP) &&
                  (s1_x_q < FB_W11) && (s1_y_q < FB_H11);
      s2_addr_d = 17'(s1_y_q) * 17'(FB_W) + 17'(s1_x_q);
      s2_data_d = bus.rom_data;
   end

   always_comb begin
      bus.rom_addr = 13'({id_q, row_q, col_q});
      bus.fb_we    = 1'b0;
      bus.fb_addr  = s2_addr_q;
      bus.fb_wdata = s2_data_q;
      if (state_q == CLEAR) begin
         bus.fb_we    = 1'b1;
         bus.fb_addr  = clr_q;
         bus.fb_wdata = bg_q;
      end else if ((state_q == DRAW) || (state_q == DRAIN)) begin
         bus.fb_we = s2_we_q;
      end
   end

   assign busy    = (state_q == CLEAR) || (state_q == DRAW) || (state_q == DRAIN);
   assign done    = (state_q == DONE);
   assign overrun = overrun_q;
endmodule

// File: doc/fb_sprite_writer.md
Name: fb_sprite_writer

Overview:
Writer side of the frame buffer. On each frame-start event it clears the back buffer to a background colour index. It then blits one 32x32 sprite from the sprite ROM into the back buffer, skipping transparent pixels and clipping at the screen edges. All colour values are 5-bit palette indices, the same encoding Color_Mapper5Bit consumes. The block runs in the Clk domain and feeds the FrameBuffer write port.

Parameters:
FB_W, 320, back-buffer width in pixels
FB_H, 240, back-buffer height in pixels
SPR_W, 32, sprite width (power of 2)
SPR_H, 32, sprite height (power of 2)
PIX_W, 5, palette index width
TRANSP, 5'h00, palette index treated as transparent (never written)

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
vs  in  1  VGA vertical sync level, active low, not yet synchronised to Clk
sprite_x  in  10  sprite left column; sampled at frame start
sprite_y  in  10  sprite top row; sampled at frame start
sprite_id  in  3  sprite ROM bank; sampled at frame start
bg_color  in  PIX_W  clear colour; sampled at frame start
rom_addr  out  13  sprite ROM address = {id, row[4:0], col[4:0]}
rom_data  in  PIX_W  ROM output for the rom_addr of the previous cycle
fb_we  out  1  frame-buffer write enable, one pixel per cycle
fb_addr  out  17  linear address = y*FB_W + x
fb_wdata  out  PIX_W  pixel index to write
busy  out  1  high from frame start until done
done  out  1  one-cycle pulse when the frame is fully written
overrun  out  1  sticky; set when a frame start arrives while busy

Behaviour:
- Reset (async): state=IDLE; all counters 0; rom_addr=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0, overrun=0; sync flops reset to 1 (vs idle high).
- Synchronising vs:
  - 2-flop synchroniser, then a falling-edge detector.
  - frame_start is asserted for one cycle on the synchronised 1->0 transition.
  - Latency from a vs edge to the frame_start cycle is 3 Clk cycles.
- FSM states: IDLE, CLEAR, DRAW, DRAIN, DONE.
- IDLE:
  - On frame_start, latch sprite_x/y, sprite_id and bg_color.
  - Set busy=1 and go to CLEAR.
- CLEAR:
  - Drive fb_we=1, fb_wdata=latched bg_color, fb_addr=0,1,...,FB_W*FB_H-1, one address per cycle.
  - The address counter is held in registers; the block does not multiply while clearing.
  - After address FB_W*FB_H-1, go to DRAW with row=col=0.
- DRAW:
  - Each cycle, present rom_addr={id,row,col}, then advance col; when col wraps from SPR_W-1 to 0, increment row.
  - Two pipeline stages follow:
    - Stage 1 holds screen x=sx+col and y=sy+row, both 11-bit so no overflow, plus a valid bit.
    - Stage 2 captures rom_data and computes fb_addr = y*FB_W + x, with FB_W a constant multiply.
  - A write is issued two cycles after its rom_addr, only when all of these hold:
    - rom_data != TRANSP
    - x < FB_W
    - y < FB_H
  - Otherwise fb_we=0 that cycle.
  - After issuing the last address (row=SPR_H-1, col=SPR_W-1), go to DRAIN.
- DRAIN:
  - Lasts 2 cycles, flushing the pipeline; the final writes occur here.
  - Then go to DONE.
- DONE:
  - done=1 for exactly 1 cycle, busy=0 in the same cycle.
  - Return to IDLE.
- Cycle budget: FB_W*FB_H + SPR_W*SPR_H + 3 cycles = 77827, well within one 60 Hz frame (about 833k cycles).
- fb_we=0 in IDLE and DONE.
- Rows of a sprite are never written out of order.
- frame_start while busy: ignored, the current frame continues unaffected, overrun=1 (cleared only by Reset).
- frame_start in the DONE cycle is also ignored and sets overrun.
- Sprite fully off-screen (sprite_x >= FB_W): DRAW still runs its full length but issues no writes; done still pulses.
- Partial clip, e.g. sprite_x=300: columns 0..19 are written and columns 20..31 are suppressed. Columns never wrap into the next row.
- Reset mid-CLEAR or mid-DRAW: fb_we drops immediately (async), no done pulse, and the block waits in IDLE for the next frame_start.

Test Plan:
1. Reset, then vs 1->0: frame_start occurs 3 cycles later, busy rises next cycle, and fb_we=1 with fb_addr=0 and fb_wdata=bg_color=5'h15 in the first CLEAR cycle; the last CLEAR write is at fb_addr=76799.
2. Sprite ROM bank 0 all 5'h1F, sprite_x=10, sprite_y=20: exactly 1024 DRAW/DRAIN writes; the first is at fb_addr=20*320+10=6410, the last at 51*320+41=16361; done pulses once, 77827 cycles after busy rose.
3. ROM returns TRANSP for even columns and 5'h03 for odd: exactly 512 sprite writes, all with wdata=5'h03 and odd x offsets.
4. sprite_x=300, sprite_y=230, ROM all 5'h07: writes only where x<320 and y<240, giving 20x10=200 writes; no fb_addr >= 76800.
5. Second vs falling edge during CLEAR: overrun=1, the frame completes normally, and exactly one done pulse occurs; the next frame_start after done is accepted.
6. Assert Reset at cycle 1000 of DRAW: fb_we, busy and done go to 0 the same cycle; after release, no writes occur until the next vs falling edge.
